// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: registers one op per handshake, performs a word-aligned req/ack access and formats load data.
// Optional LSU_MISALIGN_CHECK_EN adds wb_misalign and turns misaligned H/W accesses into faulting ops.
module ysyx_23060332_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_func3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_wen,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic              wb_wen,
  output logic [DATA_W-1:0] wb_data
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic              wb_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_mem;
  logic              w_sz_b;
  logic              w_sz_h;
  logic              w_signed;
  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [DATA_W-1:0] w_wdata;
  logic              w_misalign;
  logic              w_accept;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_load;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic [1:0]        r_off;
  logic              r_lb;
  logic              r_lh;
  logic              r_lsigned;
  logic              r_isload;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic [DATA_W-1:0] r_data;

  // Store encodings with func3[2] set are undefined and fall back to word size.
  assign w_mem    = ex_load | ex_store;
  assign w_sz_b   = (ex_func3[1:0] == 2'b00) && !(ex_store && ex_func3[2]);
  assign w_sz_h   = (ex_func3[1:0] == 2'b01) && !(ex_store && ex_func3[2]);
  assign w_signed = !ex_func3[2];
  assign w_off    = ex_addr[1:0];
  assign w_wdata  = ex_wdata << {w_off, 3'b000};
  assign w_accept = ex_valid && (r_state == S_IDLE);

  always_comb begin
    w_mask = 4'hF;
    if (w_sz_b) begin
      w_mask = 4'b0001 << w_off;
    end else if (w_sz_h) begin
      w_mask = 4'b0011 << w_off;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = w_mem && ((w_sz_h && ex_addr[0]) ||
                                (!w_sz_b && !w_sz_h && (w_off != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    if (r_lb) begin
      w_load = {{(DATA_W-8){r_lsigned & w_shifted[7]}}, w_shifted[7:0]};
    end else if (r_lh) begin
      w_load = {{(DATA_W-16){r_lsigned & w_shifted[15]}}, w_shifted[15:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ex_valid) begin
          w_next = (w_mem && !w_misalign) ? S_BUS : S_RESP;
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (wb_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_off     <= '0;
      r_lb      <= 1'b0;
      r_lh      <= 1'b0;
      r_lsigned <= 1'b0;
      r_isload  <= 1'b0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_we      <= ex_store;
      r_addr    <= {ex_addr[ADDR_W-1:2], 2'b00};
      r_wdata   <= ex_store ? w_wdata : '0;
      r_wmask   <= ex_store ? w_mask : '0;
      r_off     <= w_off;
      r_lb      <= w_sz_b;
      r_lh      <= w_sz_h;
      r_lsigned <= w_signed;
      r_isload  <= ex_load && !ex_store;
      r_rd      <= ex_rd;
      r_wen     <= ex_reg_wen && !ex_store && !w_misalign;
      r_data    <= w_misalign ? DATA_W'(ex_addr) : ex_alu;
    end else if ((r_state == S_BUS) && mem_ack && r_isload) begin
      r_data <= w_load;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= w_misalign;
    end else if ((r_state == S_RESP) && wb_ready) begin
      r_misalign <= 1'b0;
    end
  end

  assign wb_misalign = r_misalign;
`endif

  assign ex_ready  = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_BUS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = {4'b0000, r_wmask};
  assign wb_valid  = (r_state == S_RESP);
  assign wb_rd     = r_rd;
  assign wb_wen    = r_wen;
  assign wb_data   = r_data;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Bench for ysyx_23060332_lsu: hand-computed vector table, reset corner cases, randomized ops vs a byte-level model.
module tb_ysyx_23060332_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [2:0]  ex_func3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] ex_alu = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_wen = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        wb_misalign;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu),
    .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .wb_data(wb_data)
`ifdef LSU_MISALIGN_CHECK_EN
    , .wb_misalign(wb_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, alu, rdata;
    logic [4:0]  rd;
    logic        rwen;
    int unsigned dly, stall;
    logic        e_bus;
    logic [3:0]  e_mask;
    logic [31:0] e_mwdata;
    logic        e_wen;
    logic [31:0] e_data;
    logic        e_chk;
    logic        e_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
      input logic [31:0] rdata, input logic [4:0] rd, input logic rwen,
      input int unsigned dly, input int unsigned stall, input logic e_bus,
      input logic [3:0] e_mask, input logic [31:0] e_mwdata, input logic e_wen,
      input logic [31:0] e_data, input logic e_chk, input logic e_mis);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.alu = alu;
    v.rdata = rdata; v.rd = rd; v.rwen = rwen; v.dly = dly; v.stall = stall;
    v.e_bus = e_bus; v.e_mask = e_mask; v.e_mwdata = e_mwdata; v.e_wen = e_wen;
    v.e_data = e_data; v.e_chk = e_chk; v.e_mis = e_mis;
    return v;
  endfunction

  // Reference: treats memory as four bytes and moves bytes between lanes one at a time.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int unsigned n, off;
    logic sgn;
    logic [7:0] rb[4];
    logic [7:0] wb[4];
    logic [31:0] val;
    off = int'(v.addr[1:0]);
    v.e_mask = '0; v.e_mwdata = '0; v.e_mis = 1'b0;
    if (!v.ld && !v.st) begin
      v.e_bus = 1'b0; v.e_wen = v.rwen; v.e_data = v.alu; v.e_chk = 1'b1;
      return v;
    end
    if (v.st) begin
      n = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
      sgn = 1'b0;
    end else begin
      n = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
      sgn = (v.f3 == 3'd0 || v.f3 == 3'd1);
    end
`ifdef LSU_MISALIGN_CHECK_EN
    if ((n == 2 && off % 2 != 0) || (n == 4 && off != 0)) begin
      v.e_bus = 1'b0; v.e_wen = 1'b0; v.e_data = v.addr; v.e_chk = 1'b1; v.e_mis = 1'b1;
      return v;
    end
`endif
    v.e_bus = 1'b1;
    if (v.st) begin
      for (int i = 0; i < 4; i++) wb[i] = v.wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) v.e_mwdata[8*i +: 8] = (i >= off) ? wb[i-off] : 8'h00;
      if (n == 4) v.e_mask = 4'hF;
      else for (int i = 0; i < n; i++) if (off + i < 4) v.e_mask[off+i] = 1'b1;
      v.e_wen = 1'b0; v.e_data = '0; v.e_chk = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) rb[i] = v.rdata[8*i +: 8];
      val = '0;
      if (n == 4) begin
        for (int i = 0; i < 4; i++) if (off + i < 4) val[8*i +: 8] = rb[off+i];
      end else begin
        for (int i = 0; i < n; i++) if (off + i < 4) val[8*i +: 8] = rb[off+i];
        if (sgn && val[8*n-1]) val = val - (32'd1 << (8*n)) ;
      end
      v.e_wen = v.rwen; v.e_data = val; v.e_chk = 1'b1;
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_func3 = v.f3; ex_addr = v.addr;
    ex_wdata = v.wdata; ex_alu = v.alu; ex_rd = v.rd; ex_reg_wen = v.rwen;
    chk({tag, ".ex_ready_idle"}, 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_load = 1'($urandom); ex_store = 1'($urandom); ex_func3 = 3'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom; ex_alu = $urandom; ex_rd = 5'($urandom);
    if (v.e_bus) begin
      for (int unsigned c = 0; c <= v.dly; c++) begin
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.st));
        chk({tag, ".mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({tag, ".wb_valid_bus"}, 32'(wb_valid), 32'd0);
        if (v.st) begin
          chk({tag, ".mem_wmask"}, 32'(mem_wmask), {28'd0, v.e_mask});
          chk({tag, ".mem_wdata"}, mem_wdata, v.e_mwdata);
        end
        if (c < v.dly) begin
          @(posedge clk); #1;
        end
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end else begin
      chk({tag, ".no_mem_req"}, 32'(mem_req), 32'd0);
    end
    for (int unsigned s = 0; s <= v.stall; s++) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".ex_ready_resp"}, 32'(ex_ready), 32'd0);
      chk({tag, ".mem_req_resp"}, 32'(mem_req), 32'd0);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
      chk({tag, ".wb_wen"}, 32'(wb_wen), 32'(v.e_wen));
      if (v.e_chk) chk({tag, ".wb_data"}, wb_data, v.e_data);
`ifdef LSU_MISALIGN_CHECK_EN
      chk({tag, ".wb_misalign"}, 32'(wb_misalign), 32'(v.e_mis));
`endif
      if (s < v.stall) begin
        @(posedge clk); #1;
      end
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk({tag, ".wb_valid_done"}, 32'(wb_valid), 32'd0);
    chk({tag, ".ex_ready_done"}, 32'(ex_ready), 32'd1);
`ifdef LSU_MISALIGN_CHECK_EN
    chk({tag, ".wb_misalign_done"}, 32'(wb_misalign), 32'd0);
`endif
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int unsigned k;

    tbl.push_back(mk(1,0,3'b010,32'h80000004,32'h0,32'h111,32'hDEADBEEF,5'd5,1,3,0, 1,4'h0,32'h0,1,32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,0,3'b000,32'h80000003,32'h0,32'h0,32'h80123456,5'd6,1,1,1, 1,4'h0,32'h0,1,32'hFFFFFF80,1,0));
    tbl.push_back(mk(1,0,3'b100,32'h80000003,32'h0,32'h0,32'h80123456,5'd6,1,0,0, 1,4'h0,32'h0,1,32'h00000080,1,0));
    tbl.push_back(mk(1,0,3'b101,32'h80000002,32'h0,32'h0,32'h80123456,5'd8,1,2,0, 1,4'h0,32'h0,1,32'h00008012,1,0));
    tbl.push_back(mk(1,0,3'b001,32'h80000002,32'h0,32'h0,32'h80123456,5'd8,1,0,2, 1,4'h0,32'h0,1,32'hFFFF8012,1,0));
    tbl.push_back(mk(0,1,3'b001,32'h80000002,32'h1234ABCD,32'hAA,32'h0,5'd9,1,2,1, 1,4'hC,32'hABCD0000,0,32'h0,0,0));
    tbl.push_back(mk(0,1,3'b000,32'h80000001,32'h000000A5,32'h0,32'h0,5'd10,1,0,0, 1,4'h2,32'h0000A500,0,32'h0,0,0));
    tbl.push_back(mk(0,1,3'b010,32'h80000000,32'hCAFEF00D,32'h0,32'h0,5'd11,1,1,0, 1,4'hF,32'hCAFEF00D,0,32'h0,0,0));
    tbl.push_back(mk(1,1,3'b010,32'h00000020,32'h01020304,32'h0,32'h0,5'd12,1,0,0, 1,4'hF,32'h01020304,0,32'h0,0,0));
    tbl.push_back(mk(0,0,3'b000,32'h80000000,32'h0,32'h55,32'h0,5'd7,1,0,4, 0,4'h0,32'h0,1,32'h00000055,1,0));
    tbl.push_back(mk(0,0,3'b010,32'h0,32'h0,32'hFFFF0000,32'h0,5'd0,0,0,0, 0,4'h0,32'h0,0,32'hFFFF0000,1,0));
    tbl.push_back(mk(1,0,3'b011,32'h00000010,32'h0,32'h0,32'h11223344,5'd13,1,1,0, 1,4'h0,32'h0,1,32'h11223344,1,0));
    tbl.push_back(mk(1,0,3'b100,32'h00000000,32'h0,32'h0,32'h000000F0,5'd14,0,0,0, 1,4'h0,32'h0,0,32'h000000F0,1,0));
`ifdef LSU_MISALIGN_CHECK_EN
    tbl.push_back(mk(1,0,3'b010,32'h80000002,32'h0,32'h0,32'hDEADBEEF,5'd3,1,0,1, 0,4'h0,32'h0,0,32'h80000002,1,1));
    tbl.push_back(mk(0,1,3'b001,32'h80000003,32'h0000BEEF,32'h0,32'h0,5'd4,1,0,0, 0,4'h0,32'h0,0,32'h80000003,1,1));
`else
    tbl.push_back(mk(1,0,3'b010,32'h80000002,32'h0,32'h0,32'hDEADBEEF,5'd3,1,0,0, 1,4'h0,32'h0,1,32'h0000DEAD,1,0));
    tbl.push_back(mk(0,1,3'b001,32'h80000003,32'h0000BEEF,32'h0,32'h0,5'd4,1,0,0, 1,4'h8,32'hEF000000,0,32'h0,0,0));
    tbl.push_back(mk(0,1,3'b010,32'h80000001,32'h11223344,32'h0,32'h0,5'd4,1,1,0, 1,4'hF,32'h22334400,0,32'h0,0,0));
`endif

    #12;
    chk("rst.ex_ready", 32'(ex_ready), 32'd1);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_wen", 32'(wb_wen), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("rst.wb_misalign", 32'(wb_misalign), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    k = 0;
    foreach (tbl[i]) begin
      run(tbl[i], $sformatf("tbl%0d", k));
      k++;
    end

    // Reset in the middle of a bus access; a late ack must not resurrect the op.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_func3 = 3'b010;
    ex_addr = 32'h80000008; ex_reg_wen = 1'b1; ex_rd = 5'd2;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("abort.mem_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort.mem_req", 32'(mem_req), 32'd0);
    chk("abort.ex_ready", 32'(ex_ready), 32'd1);
    chk("abort.wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("abort.late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("abort.late_ack_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("abort.idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("abort.idle_ex_ready", 32'(ex_ready), 32'd1);

    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      v.ld = (kind == 1 || kind == 3);
      v.st = (kind == 2 || kind == 3);
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom; v.wdata = $urandom; v.alu = $urandom; v.rdata = $urandom;
      v.rd = 5'($urandom); v.rwen = 1'($urandom);
      v.dly = $urandom_range(0, 3); v.stall = $urandom_range(0, 2);
      run(model(v), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
